// File: rtl/pmem_pkg.sv
// -----------------------------------------------------------------------------
// pmem_pkg
// Shared types and constants for the line-granular physical memory model.
//   LINE_BITS    : width of one cache line (256 bits)
//   OFFSET_BITS  : byte-offset bits inside a line (ignored on the address)
//   line_t       : one cache line, byte 0 in bits [7:0]
//   pmem_state_t : request FSM states
//   pmem_op_t    : operation latched for the transaction in flight
// -----------------------------------------------------------------------------
package pmem_pkg;

   localparam int LINE_BITS   = 256;
   localparam int OFFSET_BITS = 5;

   typedef logic [LINE_BITS-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } pmem_state_t;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } pmem_op_t;

endpackage

// File: rtl/pmem_array.sv
// -----------------------------------------------------------------------------
// pmem_array
// Single-port synchronous line RAM.
// Ports:
//   clk   in  : clock, all accesses on the rising edge
//   we    in  : write enable, stores wline at idx
//   re    in  : read enable, loads rline from idx
//   idx   in  : line index
//   wline in  : line to write
//   rline out : last line read; holds between reads
// -----------------------------------------------------------------------------
module pmem_array
  import pmem_pkg::*;
#(
  parameter int    IDX_BITS  = 11,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_BITS-1:0] idx,
  input  line_t               wline,
  output line_t               rline
);

  localparam int DEPTH = 1 << IDX_BITS;

  line_t mem [DEPTH];

  // NOTE: the array has no reset branch -- a reset loop over every line would
  // not map onto RAM, and memory contents must survive rst_n anyway.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wline;
    if (re) rline <= mem[idx];
  end

endmodule

// File: rtl/pmem_model.sv
// -----------------------------------------------------------------------------
// pmem_model
// Line-granular physical memory model with a fixed response latency and a
// sticky protocol checker.
// Ports:
//   clk     in  : clock, rising edge
//   rst_n   in  : asynchronous active-low reset (array contents preserved)
//   read    in  : line read request
//   write   in  : line write request
//   address in  : byte address; [4:0] and [31:ADDR_BITS] ignored
//   wdata   in  : write line, byte 0 in bits [7:0]
//   resp    out : one-cycle completion pulse
//   rdata   out : last read line, valid while resp is high
//   error   out : sticky protocol-violation flag
// -----------------------------------------------------------------------------
module pmem_model
   import pmem_pkg::*;
#(
   parameter int    ADDR_BITS = 16,
   parameter int    LATENCY   = 4,
   parameter string INIT_FILE = "memory.lst"
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] address,
   input  line_t       wdata,
   output logic        resp,
   output line_t       rdata,
   output logic        error
);

   localparam int IDX_BITS = ADDR_BITS - OFFSET_BITS;
   localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

   typedef logic [IDX_BITS-1:0] idx_t;

   pmem_state_t         state, state_next;
   logic [CNT_BITS-1:0] cnt, cnt_next;
   pmem_op_t            op;
   idx_t                lat_idx;
   line_t               lat_wdata;
   logic                rdata_valid;
   logic                start, access, violation, error_next;
   idx_t                req_idx;
   line_t               rline;
   logic                unused_addr;

   assign req_idx     = address[ADDR_BITS-1:OFFSET_BITS];
   // Offset and high (aliased) address bits are intentionally ignored.
   assign unused_addr = &{1'b0, address};

   assign start = (state == IDLE) && (read ^ write);

   // Protocol checks that only apply while a transaction is counting down.
   always_comb begin
      violation = 1'b0;
      if (state == BUSY) begin
         if (op == OP_WRITE) violation = !write || read || (wdata != lat_wdata);
         else                violation = !read || write;
         if (req_idx != lat_idx) violation = 1'b1;
      end
   end

   assign error_next = error | (read & write) | violation;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   // With LATENCY=1 the counter loads 0, so BUSY lasts one cycle and resp still
   // lands LATENCY edges after the sampling edge.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      access     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = BUSY;
               cnt_next   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_next = DONE;
               access     = 1'b1;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         error       <= 1'b0;
         rdata_valid <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         error <= error_next;
         if (access && op == OP_READ) rdata_valid <= 1'b1;
      end
   end

   // Request latches are only consumed in BUSY, so they need no reset value.
   always_ff @(posedge clk) begin
      if (start) begin
         op        <= write ? OP_WRITE : OP_READ;
         lat_idx   <= req_idx;
         lat_wdata <= wdata;
      end
   end

   // The access always uses latched values, so a violating requester cannot
   // redirect or corrupt the transaction already in flight.
   pmem_array #(
      .IDX_BITS  (IDX_BITS),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .we    (access && op == OP_WRITE),
      .re    (access && op == OP_READ),
      .idx   (lat_idx),
      .wline (lat_wdata),
      .rline (rline)
   );

   assign resp = (state == DONE);
   // The RAM read register has no reset; mask it until a read lands after reset.
   assign rdata = rdata_valid ? rline : '0;

endmodule

// File: tb/tb_pmem_model.sv
// -----------------------------------------------------------------------------
// tb_pmem_model
// Scoreboard bench for pmem_model. Two instances run side by side: dut0 with
// LATENCY=4 and dut1 with LATENCY=1. Each issued request pushes its expected
// response cycle and read data; a negedge monitor pops and compares on resp.
// -----------------------------------------------------------------------------
module tb_pmem_model;
   import pmem_pkg::*;

   localparam int LAT0   = 4;
   localparam int LAT1   = 1;
   localparam int BUDGET = 20;

   localparam line_t L_DB  = {8{32'hDEADBEEF}};
   localparam line_t L_A5  = {32{8'hA5}};
   localparam line_t L_5A  = {32{8'h5A}};
   localparam line_t L_OLD = {16{16'h1234}};
   localparam line_t L_NEW = {16{16'hFEED}};
   localparam line_t L_200 = {8{32'h0200C0DE}};
   localparam line_t L_240 = {8{32'h0240F00D}};

   typedef struct {
      int    cyc;
      bit    chk;
      line_t data;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        rd_s   [2];
   logic        wr_s   [2];
   logic [31:0] addr_s [2];
   line_t       wd_s   [2];
   logic        resp_s [2];
   line_t       rdata_s[2];
   logic        err_s  [2];

   exp_t  q0[$];
   exp_t  q1[$];
   line_t last_rd[2];
   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pmem_model #(.ADDR_BITS(16), .LATENCY(LAT0), .INIT_FILE("")) dut0 (
      .clk(clk), .rst_n(rst_n), .read(rd_s[0]), .write(wr_s[0]),
      .address(addr_s[0]), .wdata(wd_s[0]),
      .resp(resp_s[0]), .rdata(rdata_s[0]), .error(err_s[0])
   );

   pmem_model #(.ADDR_BITS(16), .LATENCY(LAT1), .INIT_FILE("")) dut1 (
      .clk(clk), .rst_n(rst_n), .read(rd_s[1]), .write(wr_s[1]),
      .address(addr_s[1]), .wdata(wd_s[1]),
      .resp(resp_s[1]), .rdata(rdata_s[1]), .error(err_s[1])
   );

   task automatic check(input string name, input line_t act, input line_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Monitor: every resp pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      int   n;
      for (int d = 0; d < 2; d++) begin
         if (resp_s[d] === 1'b1) begin
            n = (d == 0) ? q0.size() : q1.size();
            if (n == 0) begin
               check($sformatf("dut%0d spurious resp", d), resp_s[d], 0);
            end else begin
               if (d == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               check($sformatf("dut%0d resp cycle", d), cyc, e.cyc);
               if (e.chk) begin
                  check($sformatf("dut%0d rdata", d), rdata_s[d], e.data);
                  last_rd[d] = e.data;
               end
            end
         end
      end
   end

   // Single transaction; caller is at #1 after an edge with the DUT idle.
   // alt != 0 moves the address one cycle into the transaction.
   task automatic xfer(input int d, input bit w, input logic [31:0] a,
                       input line_t wdat, input line_t exp_rd,
                       input bit alt, input logic [31:0] alt_a);
      exp_t e;
      int   lat  = (d == 0) ? LAT0 : LAT1;
      bit   seen = 1'b0;
      rd_s[d]   = !w;
      wr_s[d]   = w;
      addr_s[d] = a;
      wd_s[d]   = wdat;
      e.cyc  = cyc + 1 + lat;
      e.chk  = !w;
      e.data = exp_rd;
      push(d, e);
      for (int i = 0; i < BUDGET && !seen; i++) begin
         @(posedge clk); #1;
         if (alt && i == 0) addr_s[d] = alt_a;
         if (resp_s[d] === 1'b1) seen = 1'b1;
      end
      if (!seen) check($sformatf("dut%0d resp timeout", d), resp_s[d], 1);
      @(posedge clk); #1;
      rd_s[d] = 1'b0;
      wr_s[d] = 1'b0;
      if (w) check($sformatf("dut%0d rdata kept over write", d), rdata_s[d], last_rd[d]);
   endtask

   // Read held continuously across two transactions.
   task automatic b2b(input int d, input logic [31:0] a, input line_t exp_rd);
      exp_t e;
      int   lat = (d == 0) ? LAT0 : LAT1;
      int   n   = 0;
      rd_s[d]   = 1'b1;
      wr_s[d]   = 1'b0;
      addr_s[d] = a;
      e.chk  = 1'b1;
      e.data = exp_rd;
      e.cyc  = cyc + 1 + lat;
      push(d, e);
      e.cyc  = e.cyc + lat + 2;
      push(d, e);
      for (int i = 0; i < 2 * BUDGET && n < 2; i++) begin
         @(posedge clk); #1;
         if (resp_s[d] === 1'b1) n++;
      end
      if (n < 2) check($sformatf("dut%0d b2b timeout", d), resp_s[d], 1);
      @(posedge clk); #1;
      rd_s[d] = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("dut%0d reset resp", d),  resp_s[d],  0);
         check($sformatf("dut%0d reset error", d), err_s[d],   0);
         check($sformatf("dut%0d reset rdata", d), rdata_s[d], 0);
         last_rd[d] = '0;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rd_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = '0; wd_s[d] = '0;
         last_rd[d] = '0;
      end
      #1;
      do_reset();

      // Functional traffic on each instance.
      for (int d = 0; d < 2; d++) begin
         xfer(d, 1, 32'h40, L_DB, '0, 0, '0);
         xfer(d, 0, 32'h4C, '0, L_DB, 0, '0);
         check($sformatf("dut%0d error after read", d), err_s[d], 0);
         xfer(d, 1, 32'h1020, L_5A, '0, 0, '0);
         xfer(d, 1, 32'h1000, L_A5, '0, 0, '0);
         xfer(d, 0, 32'h1000, '0, L_A5, 0, '0);
         xfer(d, 0, 32'h1020, '0, L_5A, 0, '0);
         xfer(d, 0, 32'h0001_1000, '0, L_A5, 0, '0);
         b2b(d, 32'h1000, L_A5);
         xfer(d, 1, 32'h300, L_OLD, '0, 0, '0);
         xfer(d, 1, 32'h200, L_200, '0, 0, '0);
         xfer(d, 1, 32'h240, L_240, '0, 0, '0);
         check($sformatf("dut%0d error clean traffic", d), err_s[d], 0);
      end

      // Reset in the middle of a write: no resp, no commit.
      for (int d = 0; d < 2; d++) begin
         wr_s[d] = 1'b1; addr_s[d] = 32'h300; wd_s[d] = L_NEW;
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) wr_s[d] = 1'b0;
      do_reset();
      repeat (8) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         xfer(d, 0, 32'h300, '0, L_OLD, 0, '0);
         check($sformatf("dut%0d error after abort", d), err_s[d], 0);
      end

      // Simultaneous read and write for one edge: sticky error until reset.
      for (int d = 0; d < 2; d++) begin
         rd_s[d] = 1'b1; wr_s[d] = 1'b1; addr_s[d] = 32'h40;
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         rd_s[d] = 1'b0; wr_s[d] = 1'b0;
         check($sformatf("dut%0d error rd&wr", d), err_s[d], 1);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) check($sformatf("dut%0d error sticky", d), err_s[d], 1);
      do_reset();
      for (int d = 0; d < 2; d++) check($sformatf("dut%0d error cleared", d), err_s[d], 0);

      // Address change mid-transaction: error, but latched line is returned.
      for (int d = 0; d < 2; d++) begin
         xfer(d, 0, 32'h200, '0, L_200, 1, 32'h240);
         check($sformatf("dut%0d error addr change", d), err_s[d], 1);
      end

      repeat (4) @(posedge clk);
      #1;
      check("dut0 outstanding", q0.size(), 0);
      check("dut1 outstanding", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
